// File: rtl/sha256_bus_master.sv
// sha256_bus_master: register-bus initiator that loads padded blocks into the sha256 core,
// starts each block, polls for completion and reads the digest back after the last block.
module sha256_bus_master #(
    parameter int POLL_TIMEOUT = 4096,
    parameter bit CTRL_MODE    = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic         err,
    input  logic         err_clr,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [31:0]  write_data,
    input  logic [31:0]  read_data,
    input  logic         error
);
    localparam int PW = POLL_TIMEOUT > 1 ? $clog2(POLL_TIMEOUT) : 1;
    typedef enum logic [2:0] {IDLE, WRITE, CTRL, GAP, POLL, RDIG, DONE} state_t;
    state_t        state;
    logic [511:0]  blk;
    logic [255:0]  dig_sh;
    logic [PW-1:0] poll_cnt;
    logic [3:0]    idx;
    logic          first;
    logic          last;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            blk          <= '0;
            dig_sh       <= '0;
            poll_cnt     <= '0;
            idx          <= '0;
            first        <= 1'b0;
            last         <= 1'b0;
            blk_ready    <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            cs           <= 1'b0;
            we           <= 1'b0;
            address      <= '0;
            write_data   <= '0;
        end else begin
            digest_valid <= 1'b0;
            // a core error on any access abandons the block without touching the digest
            if (cs && error) begin
                err       <= 1'b1;
                cs        <= 1'b0;
                we        <= 1'b0;
                busy      <= 1'b0;
                blk_ready <= 1'b1;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        blk_ready <= 1'b1;
                        if (blk_valid && blk_ready) begin
                            blk_ready  <= 1'b0;
                            busy       <= 1'b1;
                            first      <= blk_first;
                            last       <= blk_last;
                            blk        <= {blk_data[479:0], 32'h0};
                            cs         <= 1'b1;
                            we         <= 1'b1;
                            address    <= 8'h10;
                            write_data <= blk_data[511:480];
                            idx        <= '0;
                            state      <= WRITE;
                        end
                    end
                    WRITE: begin
                        idx <= idx + 4'd1;
                        if (idx == 4'd15) begin
                            address    <= 8'h08;
                            write_data <= {29'b0, CTRL_MODE, ~first, first};
                            state      <= CTRL;
                        end else begin
                            address    <= address + 8'd1;
                            write_data <= blk[511:480];
                            blk        <= {blk[479:0], 32'h0};
                        end
                    end
                    CTRL: begin
                        cs    <= 1'b0;
                        we    <= 1'b0;
                        state <= GAP;
                    end
                    GAP: begin
                        cs       <= 1'b1;
                        address  <= 8'h09;
                        poll_cnt <= '0;
                        state    <= POLL;
                    end
                    POLL: begin
                        poll_cnt <= poll_cnt + 1'b1;
                        if (read_data[0] && last) begin
                            address <= 8'h20;
                            idx     <= '0;
                            state   <= RDIG;
                        end else if (read_data[0] || poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
                            err       <= err | ~read_data[0];
                            cs        <= 1'b0;
                            busy      <= 1'b0;
                            blk_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    RDIG: begin
                        dig_sh <= {dig_sh[223:0], read_data};
                        idx    <= idx + 4'd1;
                        if (idx == 4'd7) begin
                            cs    <= 1'b0;
                            state <= DONE;
                        end else begin
                            address <= address + 8'd1;
                        end
                    end
                    DONE: begin
                        digest       <= dig_sh;
                        digest_valid <= 1'b1;
                        busy         <= 1'b0;
                        blk_ready    <= 1'b1;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (err_clr) err <= 1'b0;
        end
    end
endmodule
